// File: rtl/div_twelve_seq.sv
// div_twelve_seq: iterative unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake so the execute stage can stall on it.
module div_twelve_seq #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] r, q, d, r_nx, q_nx;
    logic [WIDTH:0] trial_a, t;
    logic [CNT_W-1:0] cnt;
    logic accept, zero_div, last;
    // R < D always holds, so a (WIDTH+1)-bit trial difference cannot overflow its sign bit
    always_comb begin
        trial_a  = {r, q[WIDTH-1]};
        t        = trial_a + {1'b1, ~d} + (WIDTH+1)'(1);
        r_nx     = t[WIDTH] ? trial_a[WIDTH-1:0] : t[WIDTH-1:0];
        q_nx     = {q[WIDTH-2:0], ~t[WIDTH]};
        accept   = start && (state != RUN);
        zero_div = divisor == '0;
        last     = cnt == CNT_W'(WIDTH-1);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = state == RUN ? (last ? FIN : RUN)
                 : accept       ? (zero_div ? FIN : RUN)
                 :                IDLE;
    end
    always_comb begin
        busy = state == RUN;
        done = state == FIN;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (state == RUN) begin
            r   <= r_nx;
            q   <= q_nx;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                quotient  <= q_nx;
                remainder <= r_nx;
            end
        end else if (accept && zero_div) begin
            quotient  <= '1;
            remainder <= dividend;
            div_zero  <= 1'b1;
        end else if (accept) begin
            r        <= '0;
            q        <= dividend;
            d        <= divisor;
            cnt      <= '0;
            div_zero <= 1'b0;
        end
    end
endmodule

// File: doc/div_twelve_seq.md
Name: div_twelve_seq

Overview:
- Iterative unsigned restoring divider for the processor datapath.
- Performs the inverse of the 12-bit adder/multiplier path: it produces quotient and remainder one bit per clock.
- Each trial subtraction is computed as A + ~B + 1 on a (WIDTH+1)-bit add path.
- Uses a start/busy/done handshake so the execute stage can stall on it.

Parameters:
- WIDTH, 12, operand/result width in bits.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled on a rising edge.
- dividend  input  WIDTH  numerator; captured when start is accepted.
- divisor  input  WIDTH  denominator; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse marking valid results.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.
- div_zero  output  1  divisor was zero for the last operation; held with the results.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0, internal registers=0. Reset during RUN aborts the operation immediately with no done pulse.
- States: IDLE, RUN, FIN.
- Start acceptance:
  - start is accepted only in IDLE or FIN.
  - start asserted while in RUN is ignored and does not queue.
- IDLE/FIN with start=1 and divisor!=0:
  - Load the partial remainder register R={(WIDTH+1){0}}.
  - Load the quotient shift register Q=dividend and the divisor register D=divisor.
  - Set counter=0, div_zero=0, go to RUN, busy=1.
  - The visible quotient/remainder outputs keep their previous values until FIN.
- IDLE/FIN with start=1 and divisor==0:
  - Go to FIN on the next edge with quotient={WIDTH{1}}, remainder=dividend, div_zero=1.
  - busy stays 0; done pulses in that FIN cycle.
- RUN, each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed at WIDTH+1 bits.
  - If T is non-negative (bit WIDTH = 0): R<=T and Q<={Q[WIDTH-2:0],1}.
  - Otherwise: R<={R[WIDTH-1:0],Q[WIDTH-1]} and Q<={Q[WIDTH-2:0],0}.
  - counter increments each cycle. When counter==WIDTH-1 the final iteration completes and the state goes to FIN.
  - On that same edge, quotient/remainder load from the final Q/R[WIDTH-1:0].
- FIN:
  - done=1 for exactly one cycle; busy=0.
  - With no start, the next state is IDLE. With start, the next state is RUN (back-to-back operation) or FIN again (divide by zero).
- Latency: start sampled at edge k → busy high from after edge k through edge k+WIDTH → done high in the cycle after edge k+WIDTH (13 edges total for WIDTH=12). Divide by zero takes 1 edge.
- done and busy are never high simultaneously.
- Arithmetic is unsigned only; the result never overflows (quotient ≤ dividend).
- Inputs are ignored outside the accepting cycle, so operands may change during RUN without effect.

Test Plan:
- Basic divide: reset_n low 2 cycles then high; start 1 cycle with dividend=100, divisor=7 → busy for 12 cycles; done pulses 13 edges after start with quotient=14, remainder=2, div_zero=0.
- Extremes:
  - 4095/1 → quotient=4095, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 4095/4095 → quotient=1, remainder=0.
- Divide by zero: dividend=1234, divisor=0 → done on the next cycle, busy never asserted; quotient=12'hFFF, remainder=1234, div_zero=1. A following 10/3 clears div_zero (quotient=3, remainder=1).
- Busy and back-to-back starts:
  - start 200/9 with a second start (50/5) pulsed 5 cycles later → second start ignored; results 22/2.
  - start asserted in the done cycle with 50/5 → accepted; results 10/0 after another 13 edges.
  - Operand changes during RUN do not alter results.
- Reset mid-op: start 1000/3, drop reset_n asynchronously (between edges) at cycle 6 → all outputs 0 immediately, no done pulse. After release, 1000/3 → quotient=333, remainder=1.
- Random sweep: 10k random pairs with divisor≠0 checked against a reference model; quotient*divisor+remainder==dividend and remainder<divisor.
